// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter
// Shares one 32-bit Wishbone memory slave between the SERV instruction bus
// (read-only) and data bus. A registered grant FSM alternates between the two
// masters on collisions. A per-transfer watchdog ends a stalled cycle locally:
// it returns ERR_RDT and pulses o_err.

module wb_mem_arbiter #(
  parameter int          TIMEOUT = 16,
  parameter logic [31:0] ERR_RDT = 32'h0000_0013
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  // instruction bus (read-only master)
  input  logic [31:0] wb_ibus_adr,
  input  logic        wb_ibus_cyc,
  output logic [31:0] wb_ibus_rdt,
  output logic        wb_ibus_ack,
  // data bus master
  input  logic [31:0] wb_dbus_adr,
  input  logic [31:0] wb_dbus_dat,
  input  logic [3:0]  wb_dbus_sel,
  input  logic        wb_dbus_we,
  input  logic        wb_dbus_cyc,
  output logic [31:0] wb_dbus_rdt,
  output logic        wb_dbus_ack,
  // shared memory slave
  output logic [31:0] wb_mem_adr,
  output logic [31:0] wb_mem_dat,
  output logic [3:0]  wb_mem_sel,
  output logic        wb_mem_we,
  output logic        wb_mem_cyc,
  input  logic [31:0] wb_mem_rdt,
  input  logic        wb_mem_ack,
  // status
  output logic        o_err,
  output logic [1:0]  o_owner
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Count value held during the cycle in which the count reaches TIMEOUT.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  // The state encoding doubles as the o_owner code.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_GNT_I = 2'b01,
    S_GNT_D = 2'b10
  } state_t;

  state_t        r_state;
  logic          r_lastGntD;
  logic [CW-1:0] r_cnt;

  logic w_gntI;
  logic w_gntD;
  logic w_ownerCyc;
  logic w_timeout;
  logic w_done;

  assign w_gntI = (r_state == S_GNT_I);
  assign w_gntD = (r_state == S_GNT_D);

  // The current owner still holds its cycle request.
  assign w_ownerCyc = (w_gntI & wb_ibus_cyc) | (w_gntD & wb_dbus_cyc);

  // The watchdog fires only when the slave has not answered in the limit cycle.
  // If the slave acks in that same cycle, the slave wins.
  assign w_timeout = w_ownerCyc & ~wb_mem_ack & (r_cnt == CNT_LAST);

  // A granted transfer ends on a slave ack, a watchdog expiry, or an abandoned request.
  assign w_done = (w_gntI | w_gntD) & (wb_mem_ack | w_timeout | ~w_ownerCyc);

  // Grant FSM, fairness pointer and watchdog counter.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state    <= S_IDLE;
      r_lastGntD <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (wb_ibus_cyc && wb_dbus_cyc) begin
            if (r_lastGntD) begin
              r_state    <= S_GNT_I;
              r_lastGntD <= 1'b0;
            end else begin
              r_state    <= S_GNT_D;
              r_lastGntD <= 1'b1;
            end
          end else if (wb_ibus_cyc) begin
            r_state    <= S_GNT_I;
            r_lastGntD <= 1'b0;
          end else if (wb_dbus_cyc) begin
            r_state    <= S_GNT_D;
            r_lastGntD <= 1'b1;
          end
        end
        S_GNT_I, S_GNT_D: begin
          if (w_done) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Slave request fields come from the owner only. The instruction bus is a fixed full-word read.
  always_comb begin
    wb_mem_adr = 32'h0;
    wb_mem_dat = 32'h0;
    wb_mem_sel = 4'h0;
    wb_mem_we  = 1'b0;
    if (w_gntI) begin
      wb_mem_adr = wb_ibus_adr;
      wb_mem_sel = 4'hF;
    end else if (w_gntD) begin
      wb_mem_adr = wb_dbus_adr;
      wb_mem_dat = wb_dbus_dat;
      wb_mem_sel = wb_dbus_sel;
      wb_mem_we  = wb_dbus_we;
    end
  end

  // The slave request is withdrawn in the cycle the watchdog takes over.
  assign wb_mem_cyc = w_ownerCyc & ~w_timeout;

  // Acks and read data go to the owner only. On a timeout the arbiter acks with ERR_RDT itself.
  always_comb begin
    wb_ibus_ack = 1'b0;
    wb_ibus_rdt = 32'h0;
    wb_dbus_ack = 1'b0;
    wb_dbus_rdt = 32'h0;
    if (w_gntI) begin
      wb_ibus_ack = wb_mem_ack | w_timeout;
      wb_ibus_rdt = w_timeout ? ERR_RDT : wb_mem_rdt;
    end else if (w_gntD) begin
      wb_dbus_ack = wb_mem_ack | w_timeout;
      wb_dbus_rdt = w_timeout ? ERR_RDT : wb_mem_rdt;
    end
  end

  assign o_err   = w_timeout;
  assign o_owner = r_state;

endmodule
